// File: rtl/tqvp_crc32_pkg.sv
// Shared constants, state encoding and bit-reflection helpers for the TinyQV CRC-32 peripheral.
package tqvp_crc32_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_DATA   = 6'h04;
  localparam logic [5:0] ADDR_RESULT = 6'h08;
  localparam logic [5:0] ADDR_STATUS = 6'h0C;
  localparam logic [5:0] ADDR_SEED   = 6'h10;
  localparam logic [5:0] ADDR_POLY   = 6'h14;

  localparam int CTRL_INIT      = 0;
  localparam int CTRL_REFIN     = 1;
  localparam int CTRL_REFOUT    = 2;
  localparam int CTRL_XOROUT_EN = 3;
  localparam int CTRL_IRQ_EN    = 4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  localparam logic [4:0]  CTRL_RESET         = 5'h1E;
  localparam logic [31:0] CRC32_POLY_DEFAULT = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_XOROUT       = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Reverses bit order inside each byte while keeping byte order.
  function automatic logic [31:0] reflect_bytes(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++) r[8*b+k] = v[8*b+7-k];
    return r;
  endfunction

endpackage

// File: rtl/tqvp_crc32_engine_lfsr_step.sv
// Combinational MSB-first CRC-32 LFSR unrolled over BITS data bits; i_data[0] is fed first.
module crc32_lfsr_step #(
  parameter int BITS = 1
) (
  input  logic [31:0]     i_crc,
  input  logic [31:0]     i_poly,
  input  logic [BITS-1:0] i_data,
  output logic [31:0]     o_crc
);

  logic [31:0] w_acc;
  logic        w_fb;

  always_comb begin
    // NOTE: blocking assignments here chain the unrolled bit steps within one evaluation.
    w_acc = i_crc;
    w_fb  = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      w_fb  = w_acc[31] ^ i_data[i];
      w_acc = {w_acc[30:0], 1'b0} ^ (w_fb ? i_poly : 32'h0);
    end
    o_crc = w_acc;
  end

endmodule

// File: rtl/tqvp_crc32_engine.sv
// TinyQV CRC-32 peripheral: register bus, IDLE/RUN sequencer and LFSR datapath.
// Define CRC32_POLY_REG_EN to make POLY (0x14) a writable register instead of a constant.
module tqvp_crc32_engine
  import tqvp_crc32_pkg::*;
#(
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] SEED_RESET     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int LOG2_BPC = $clog2(BITS_PER_CYCLE);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
      BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_e      r_state;
  logic [31:0] r_crc;
  logic [31:0] r_seed;
  logic [31:0] r_shift;
  logic [5:0]  r_cnt;
  logic [4:0]  r_ctrl;
  logic        r_done;
  logic        r_overrun;

  logic        w_wr, w_rd, w_busy, w_init, w_finish, w_poly_ovr;
  logic        w_wr_ctrl, w_wr_data, w_wr_status, w_wr_seed;
  logic [5:0]  w_nbits, w_cnt_load;
  logic [31:0] w_shift_load, w_crc_next, w_poly, w_result;
  logic        w_unused;

  assign w_unused    = &{1'b0, ui_in};
  assign w_wr        = (data_write_n != 2'b11);
  assign w_rd        = (data_read_n != 2'b11);
  assign w_busy      = (r_state == RUN);
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_wr_data   = w_wr && (address == ADDR_DATA);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);
  assign w_wr_seed   = w_wr && (address == ADDR_SEED);
  assign w_init      = w_wr_ctrl && data_in[CTRL_INIT];
  // An INIT landing on the last RUN cycle aborts rather than completes.
  assign w_finish    = w_busy && (r_cnt == 6'd0) && !w_init;

`ifdef CRC32_POLY_REG_EN
  logic r_poly_unused;
  logic [31:0] r_poly;
  assign r_poly_unused = 1'b0;
  assign w_poly        = r_poly;
  assign w_poly_ovr    = w_wr && (address == ADDR_POLY) && w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_poly <= CRC32_POLY_DEFAULT;
    else if (w_wr && (address == ADDR_POLY) && !w_busy) r_poly <= data_in;
  end
`else
  assign w_poly     = CRC32_POLY_DEFAULT;
  assign w_poly_ovr = 1'b0;
`endif

  always_comb begin
    // NOTE: every branch of a combinational case must assign, or a latch is inferred.
    case (data_write_n)
      2'b00:   w_nbits = 6'd8;
      2'b01:   w_nbits = 6'd16;
      default: w_nbits = 6'd32;
    endcase
  end

  assign w_cnt_load = (w_nbits >> LOG2_BPC) - 6'd1;
  // The shift register always streams LSB-first; REFIN=0 pre-reverses each byte.
  assign w_shift_load = r_ctrl[CTRL_REFIN] ? data_in : reflect_bytes(data_in);

  crc32_lfsr_step #(.BITS(BITS_PER_CYCLE)) u_step (
    .i_crc  (r_crc),
    .i_poly (w_poly),
    .i_data (r_shift[BITS_PER_CYCLE-1:0]),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_crc     <= SEED_RESET;
      r_seed    <= SEED_RESET;
      r_shift   <= 32'h0;
      r_cnt     <= 6'd0;
      r_ctrl    <= CTRL_RESET;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; later lines take priority.
      if (w_wr_ctrl) r_ctrl <= {data_in[4:1], 1'b0};
      if (w_wr_seed) r_seed <= data_in;

      case (r_state)
        IDLE: if (w_wr_data) begin
          r_shift <= w_shift_load;
          r_cnt   <= w_cnt_load;
          r_state <= RUN;
        end
        RUN: begin
          r_crc   <= w_crc_next;
          r_shift <= r_shift >> BITS_PER_CYCLE;
          if (r_cnt == 6'd0) r_state <= IDLE;
          else               r_cnt   <= r_cnt - 6'd1;
        end
        default: r_state <= IDLE;
      endcase

      if (w_init) begin
        r_crc   <= r_seed;
        r_state <= IDLE;
      end

      if (w_finish)                               r_done <= 1'b1;
      else if (w_wr_status && data_in[STAT_DONE]) r_done <= 1'b0;

      if ((w_wr_data && w_busy) || w_poly_ovr)       r_overrun <= 1'b1;
      else if (w_wr_status && data_in[STAT_OVERRUN]) r_overrun <= 1'b0;
    end
  end

  assign w_result = (r_ctrl[CTRL_REFOUT] ? bit_reverse32(r_crc) : r_crc)
                  ^ (r_ctrl[CTRL_XOROUT_EN] ? CRC32_XOROUT : 32'h0);

  always_comb begin
    data_out = 32'h0;
    if (w_rd) begin
      case (address)
        ADDR_CTRL:   data_out = {27'h0, r_ctrl[4:1], 1'b0};
        ADDR_RESULT: data_out = w_result;
        ADDR_STATUS: data_out = {29'h0, r_overrun, r_done, w_busy};
        ADDR_SEED:   data_out = r_seed;
        ADDR_POLY:   data_out = w_poly;
        default:     data_out = 32'h0;
      endcase
    end
  end

  // RESULT reads stall while the LFSR is still running.
  assign data_ready     = w_rd && !((address == ADDR_RESULT) && w_busy);
  assign uo_out         = {6'h0, r_done, w_busy};
  assign user_interrupt = r_ctrl[CTRL_IRQ_EN] & r_done;

endmodule

// File: tb/tb_tqvp_crc32_engine.sv
// Self-checking bench for tqvp_crc32_engine: directed vectors plus randomized runs vs a byte-wise CRC model.
module tb_tqvp_crc32_engine;

  localparam int BPC = 1;

  localparam logic [5:0] A_CTRL = 6'h00, A_DATA = 6'h04, A_RESULT = 6'h08;
  localparam logic [5:0] A_STATUS = 6'h0C, A_SEED = 6'h10, A_POLY = 6'h14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_vec = 0;
  int n_err = 0;

  tqvp_crc32_engine #(.BITS_PER_CYCLE(BPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-wise textbook CRC: xor the byte into the top, then eight shift/conditional-xor steps.
  function automatic logic [31:0] model_byte(input logic [31:0] c, input logic [7:0] b,
                                             input logic [31:0] poly, input bit refin);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) x[i] = refin ? b[7-i] : b[i];
    c = c ^ {x, 24'h0};
    for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ poly) : (c << 1);
    return c;
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] c, input bit refout, input bit xorout);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = refout ? c[31-i] : c[i];
    return xorout ? ~r : r;
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address = a; data_in = d; data_write_n = wn;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output int stalls);
    address = a; data_read_n = 2'b10; stalls = 0;
    #1;
    while (!data_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (!data_ready) check("read_timeout", {31'h0, data_ready}, 32'h1);
    d = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int st;
    bus_read(a, d, st);
    check(tag, d, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (uo_out[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (uo_out[0]) check("idle_timeout", {31'h0, uo_out[0]}, 32'h0);
  endtask

  logic [31:0] rd;
  int          stalls;
  logic [31:0] m_crc, seed, d;
  logic [2:0]  flags;
  logic [1:0]  wn;
  int          nbytes;
  logic [7:0]  msg [9];

  initial begin
    rst_n = 1'b0; ui_in = 8'h0; address = 6'h0; data_in = 32'h0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    #23 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_uo_out", {24'h0, uo_out}, 32'h0);
    check("rst_irq", {31'h0, user_interrupt}, 32'h0);
    check("rst_ready_idle", {31'h0, data_ready}, 32'h0);
    rd_check("rst_ctrl", A_CTRL, 32'h1E);
    rd_check("rst_seed", A_SEED, 32'hFFFF_FFFF);
    rd_check("rst_status", A_STATUS, 32'h0);
    rd_check("rst_result", A_RESULT, 32'h0);
    rd_check("unmapped", 6'h20, 32'h0);

    // "123456789" as two words and a byte
    bus_write(A_CTRL, 32'h1F, 2'b10);
    bus_write(A_DATA, 32'h3433_3231, 2'b10); wait_idle();
    bus_write(A_DATA, 32'h3837_3635, 2'b10); wait_idle();
    bus_write(A_DATA, 32'h0000_0039, 2'b00); wait_idle();
    rd_check("check_value", A_RESULT, 32'hCBF4_3926);
    rd_check("check_status", A_STATUS, 32'h2);
    check("check_irq", {31'h0, user_interrupt}, 32'h1);

    // RESULT read stalls while busy
    bus_write(A_STATUS, 32'h6, 2'b10);
    bus_write(A_CTRL, 32'h1F, 2'b10);
    bus_write(A_DATA, 32'h61, 2'b00);
    bus_read(A_RESULT, rd, stalls);
    check("stall_cycles", stalls, 8 / BPC);
    check("stall_value", rd, 32'hE8B7_BE43);

    // Overrun: second DATA write three cycles into a word run
    bus_write(A_STATUS, 32'h6, 2'b10);
    bus_write(A_CTRL, 32'h1F, 2'b10);
    bus_write(A_DATA, 32'hDEAD_BEEF, 2'b10);
    repeat (2) @(negedge clk);
    bus_write(A_DATA, 32'h1234_5678, 2'b10);
    rd_check("ovr_status_run", A_STATUS, 32'h5);
    wait_idle();
    m_crc = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) m_crc = model_byte(m_crc, 8'(32'hDEAD_BEEF >> (8*k)), 32'h04C1_1DB7, 1'b1);
    rd_check("ovr_result", A_RESULT, model_result(m_crc, 1'b1, 1'b1));
    bus_write(A_STATUS, 32'h4, 2'b10);
    rd_check("ovr_cleared", A_STATUS, 32'h2);

    // Interrupt rise and W1C fall
    bus_write(A_STATUS, 32'h2, 2'b10);
    bus_write(A_CTRL, 32'h1F, 2'b10);
    bus_write(A_DATA, 32'h0, 2'b00);
    check("irq_low_busy", {31'h0, user_interrupt}, 32'h0);
    wait_idle();
    check("irq_high", {31'h0, user_interrupt}, 32'h1);
    rd_check("irq_result", A_RESULT, 32'hD202_EF8D);
    bus_write(A_STATUS, 32'h2, 2'b10);
    check("irq_cleared", {31'h0, user_interrupt}, 32'h0);

    // W1C landing on the completion edge: set wins
    bus_write(A_CTRL, 32'h1F, 2'b10);
    bus_write(A_DATA, 32'h0, 2'b00);
    repeat (8 / BPC - 1) @(negedge clk);
    bus_write(A_STATUS, 32'h2, 2'b10);
    rd_check("w1c_race_status", A_STATUS, 32'h2);
    check("w1c_race_irq", {31'h0, user_interrupt}, 32'h1);

    // Randomized runs against the model
    for (int it = 0; it < 20; it++) begin
      flags = 3'($urandom_range(0, 7));
      seed  = $urandom;
      bus_write(A_SEED, seed, 2'b10);
      bus_write(A_CTRL, {27'h0, 1'b0, flags, 1'b1}, 2'b10);
      m_crc = seed;
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        wn = 2'($urandom_range(0, 2));
        d  = $urandom;
        bus_write(A_DATA, d, wn);
        nbytes = (wn == 2'b00) ? 1 : (wn == 2'b01) ? 2 : 4;
        for (int k = 0; k < nbytes; k++)
          m_crc = model_byte(m_crc, d[8*k +: 8], 32'h04C1_1DB7, flags[0]);
        wait_idle();
      end
      rd_check($sformatf("rand_%0d", it), A_RESULT, model_result(m_crc, flags[1], flags[2]));
    end

    // Reset mid-RUN
    bus_write(A_DATA, 32'hCAFE_F00D, 2'b10);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {24'h0, uo_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_check("rst_mid_result", A_RESULT, 32'h0);
    rd_check("rst_mid_ctrl", A_CTRL, 32'h1E);
    rd_check("rst_mid_status", A_STATUS, 32'h0);

`ifdef CRC32_POLY_REG_EN
    rd_check("poly_reset", A_POLY, 32'h04C1_1DB7);
    bus_write(A_POLY, 32'h1EDC_6F41, 2'b10);
    rd_check("poly_written", A_POLY, 32'h1EDC_6F41);
    bus_write(A_CTRL, 32'h1F, 2'b10);
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    foreach (msg[i]) begin
      bus_write(A_DATA, {24'h0, msg[i]}, 2'b00);
      if (i == 0) begin
        bus_write(A_POLY, 32'h0, 2'b10);
        rd_check("poly_busy_ovr", A_STATUS, 32'h5);
      end
      wait_idle();
    end
    rd_check("crc32c_value", A_RESULT, 32'hE306_9283);
    rd_check("poly_kept", A_POLY, 32'h1EDC_6F41);
`else
    msg = '{default: 8'h0};
    bus_write(A_POLY, 32'h1EDC_6F41, 2'b10);
    rd_check("poly_const", A_POLY, 32'h04C1_1DB7);
    rd_check("poly_no_ovr", A_STATUS, {29'h0, msg[0][2:0]});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tqvp_crc32_engine.md
Name: tqvp_crc32_engine

Overview:
- TinyQV peripheral that computes a CRC-32 over bytes written through the peripheral register bus; the register/SPI harness drives it directly.
- Bytes written to DATA are shifted through an LFSR datapath at BITS_PER_CYCLE bits per clock.
- Software polls STATUS or takes the level interrupt, then reads RESULT.
- Defaults give standard CRC-32 (IEEE 802.3).

Parameters:
- BITS_PER_CYCLE, 1: LFSR bits processed per clock. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
- SEED_RESET, 32'hFFFFFFFF: reset value of SEED.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ui_in  input  8  synchronized pins; unused
- uo_out  output  8  [0]=busy, [1]=done, [7:2]=0
- address  input  6  register byte address
- data_in  input  32  write data
- data_write_n  input  2  11=idle, 00=byte, 01=half, 10=word write
- data_read_n  input  2  11=idle, else read of that width
- data_out  output  32  read data, full 32 bits always driven
- data_ready  output  1  read data valid
- user_interrupt  output  1  level interrupt

Behaviour:
- Reset (async, rst_n low) sets all outputs to 0 except as stated below:
  - CTRL=0x1E, SEED=SEED_RESET, crc=SEED_RESET.
  - State IDLE; busy, done and overrun cleared.
- Register map; any other address reads 0 and ignores writes:
  - 0x00 CTRL: bit0 INIT (write-1 loads crc<=SEED; self-clearing, reads 0), bit1 REFIN, bit2 REFOUT, bit3 XOROUT_EN, bit4 IRQ_EN.
  - 0x04 DATA: write only.
  - 0x08 RESULT: read only.
  - 0x0C STATUS: bit0 busy (RO), bit1 done (W1C), bit2 overrun (W1C).
  - 0x10 SEED: R/W.
  - 0x14 POLY: see Optional Feature.
- CTRL, SEED and POLY take data_in[31:0] on any write width.
- DATA write in IDLE:
  - Latch data_in into the shift register, byte count = 1, 2 or 4 by width.
  - Enter RUN next cycle. Bytes are processed LSB byte first.
  - Write cycle N: busy=1 from N+1; final crc valid and busy=0 at N+1+(8*bytes/BITS_PER_CYCLE).
  - Example: one word at BITS_PER_CYCLE=1 takes 32 RUN cycles.
- DATA write in RUN: data is dropped, overrun<=1, and the computation continues unaffected.
- LFSR: MSB-first form with polynomial POLY.
  - Each bit: fb = crc[31]^d; crc = {crc[30:0],1'b0} ^ (fb ? POLY : 0).
  - REFIN=1: each byte is fed LSB-first; REFIN=0: MSB-first.
- RESULT = (REFOUT ? bitreverse32(crc) : crc) ^ (XOROUT_EN ? 32'hFFFFFFFF : 0).
- RUN->IDLE: sets done=1.
- INIT write:
  - In any state: aborts RUN, loads seed, busy=0, done unchanged.
  - INIT together with a DATA write in the same cycle is impossible (one address per cycle).
- STATUS W1C of done in the same cycle that RUN completes: set wins, done=1.
- Read handshake:
  - data_ready=1 in the same cycle as data_read_n!=11 for all registers except RESULT while busy.
  - RESULT read while busy: data_ready held 0 (stall) until the first cycle busy=0, then data_ready=1 with the final value. The bus holds address and data_read_n stable meanwhile.
  - data_ready=0 when not reading.
- user_interrupt = IRQ_EN & done.
- Reset mid-RUN: abort immediately, all state to reset values.

Optional Feature:
- CRC32_POLY_REG_EN defined:
  - POLY at 0x14 is R/W, reset 32'h04C11DB7.
  - Write to POLY while busy is ignored and sets overrun.
- Not defined:
  - POLY is constant 32'h04C11DB7; 0x14 reads that value and writes are ignored.
  - No flops for POLY.

Decomposition:
- Package tqvp_crc32_pkg holds:
  - Register address localparams (ADDR_CTRL..ADDR_POLY).
  - CTRL/STATUS bit index constants.
  - CRC32_POLY_DEFAULT=32'h04C11DB7, CRC32_XOROUT=32'hFFFFFFFF.
  - State enum {IDLE, RUN}.
- One sub-module, crc32_lfsr_step: combinational BITS_PER_CYCLE-bit unrolled LFSR update, inputs crc, poly and data bits, output next crc. The top holds registers, FSM, counter and the bus interface.

Test Plan:
- Reset, then read CTRL, SEED, STATUS -> 0x1E, 0xFFFFFFFF, 0x0.
- INIT; word writes 0x34333231 and 0x38373635; byte write 0x39; poll until busy=0; read RESULT -> 0xCBF43926, done=1.
- INIT; byte write 0x61; immediately read RESULT -> data_ready low for 8 cycles (BITS_PER_CYCLE=1), then 0xE8B7BE43.
- INIT; word write then a second DATA write 3 cycles later -> STATUS=0x5 during the run; final RESULT equals the single-word CRC; W1C 0x4 -> overrun cleared.
- IRQ_EN=1; byte write 0x00 -> user_interrupt rises at completion, RESULT=0xD202EF8D; STATUS write 0x2 -> interrupt falls. Repeat with the W1C landing on the completion cycle -> done stays 1.
- Word write, then assert rst_n low mid-RUN -> busy=0 and RESULT=0x00000000 after release (crc=FFFFFFFF reflected, then XOR FFFFFFFF).
- If CRC32_POLY_REG_EN is defined: POLY=0x1EDC6F41, INIT, then "123456789" -> RESULT 0xE3069283 (CRC-32C).
